// File: rtl/icache_assoc_if.sv
// Fetch-side and program-memory-side handshakes of the two-way instruction cache.
// master = core fetcher plus memory controller, slave = cache.
interface icache_assoc_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
);
   logic                 read_valid;
   logic [ADDR_BITS-1:0] read_address;
   logic                 read_ready;
   logic [DATA_BITS-1:0] read_data;
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;

   modport master (
      output read_valid, read_address, mem_read_ready, mem_read_data,
      input  read_ready, read_data, mem_read_valid, mem_read_address
   );

   modport slave (
      input  read_valid, read_address, mem_read_ready, mem_read_data,
      output read_ready, read_data, mem_read_valid, mem_read_address
   );
endinterface

// File: rtl/icache_assoc.sv
// Two-way set-associative instruction cache: per-set LRU, word-by-word line refill,
// set-serial flush and saturating hit/miss statistics.
//
// state        | meaning
// S_IDLE       | waiting for a fetch or a flush
// S_LOOKUP     | tag compare on the latched address
// S_REFILL_REQ | memory request for one beat held until accepted
// S_REFILL_GAP | one idle cycle between beats, advance beat
// S_RESPOND    | return the freshly filled word
// S_FLUSH      | invalidate one set per cycle
module icache_assoc #(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_BITS  = 16,
   parameter int NUM_SETS   = 4,
   parameter int LINE_WORDS = 4,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   icache_assoc_if.slave         bus,
   input  logic                  flush,
   output logic                  busy,
   output logic [COUNT_BITS-1:0] hit_count,
   output logic [COUNT_BITS-1:0] miss_count
);
   localparam int OFF = $clog2(LINE_WORDS);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = ADDR_BITS - IDX - OFF;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_GAP, S_RESPOND, S_FLUSH
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_BITS-1:0] addr_q;
   logic                 victim_q;
   logic [OFF-1:0]       beat_q;
   logic [IDX-1:0]       flush_idx;
   logic                 flush_pend;
   logic [NUM_SETS-1:0]  valid [2];
   logic [NUM_SETS-1:0]  lru;
   logic [TAG-1:0]       tag_mem  [2][NUM_SETS];
   logic [DATA_BITS-1:0] data_mem [2][NUM_SETS][LINE_WORDS];

   logic [OFF-1:0] a_off;
   logic [IDX-1:0] a_idx;
   logic [TAG-1:0] a_tag;
   logic           hit, hit_way, victim, last_beat, go_flush, go_lookup;

   assign a_off = addr_q[OFF-1:0];
   assign a_idx = addr_q[IDX+OFF-1:OFF];
   assign a_tag = addr_q[ADDR_BITS-1:IDX+OFF];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (go_flush) state_nxt = S_FLUSH;
                       else if (go_lookup) state_nxt = S_LOOKUP;
         S_LOOKUP:     state_nxt = hit ? S_IDLE : S_REFILL_REQ;
         S_REFILL_REQ: if (bus.mem_read_ready) state_nxt = last_beat ? S_RESPOND : S_REFILL_GAP;
         S_REFILL_GAP: state_nxt = S_REFILL_REQ;
         S_RESPOND:    state_nxt = S_IDLE;
         S_FLUSH:      if (flush_idx == IDX'(NUM_SETS - 1)) state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      go_flush  = flush | flush_pend;
      go_lookup = bus.read_valid & ~bus.read_ready;
      hit_way   = valid[1][a_idx] && (tag_mem[1][a_idx] == a_tag);
      hit       = hit_way | (valid[0][a_idx] && (tag_mem[0][a_idx] == a_tag));
      // Prefer an empty way before evicting the least-recently-used one.
      victim    = ~valid[0][a_idx] ? 1'b0 : (~valid[1][a_idx] ? 1'b1 : lru[a_idx]);
      last_beat = (beat_q == OFF'(LINE_WORDS - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q               <= '0;
         victim_q             <= 1'b0;
         beat_q               <= '0;
         flush_idx            <= '0;
         flush_pend           <= 1'b0;
         valid[0]             <= '0;
         valid[1]             <= '0;
         lru                  <= '0;
         hit_count            <= '0;
         miss_count           <= '0;
         bus.read_ready       <= 1'b0;
         bus.read_data        <= '0;
         bus.mem_read_valid   <= 1'b0;
         bus.mem_read_address <= '0;
      end else begin
         bus.read_ready <= 1'b0;
         if (flush && state != S_IDLE) flush_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (go_flush) begin
                  flush_pend <= 1'b0;
                  flush_idx  <= '0;
               end else if (go_lookup) begin
                  addr_q <= bus.read_address;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  bus.read_data  <= data_mem[hit_way][a_idx][a_off];
                  bus.read_ready <= 1'b1;
                  lru[a_idx]     <= ~hit_way;
                  if (~&hit_count) hit_count <= hit_count + COUNT_BITS'(1);
               end else begin
                  if (~&miss_count) miss_count <= miss_count + COUNT_BITS'(1);
                  victim_q             <= victim;
                  beat_q               <= '0;
                  bus.mem_read_valid   <= 1'b1;
                  bus.mem_read_address <= {a_tag, a_idx, {OFF{1'b0}}};
               end
            end
            S_REFILL_REQ: begin
               if (bus.mem_read_ready) begin
                  bus.mem_read_valid <= 1'b0;
                  if (last_beat) begin
                     valid[victim_q][a_idx] <= 1'b1;
                     lru[a_idx]             <= ~victim_q;
                  end
               end
            end
            S_REFILL_GAP: begin
               beat_q               <= beat_q + OFF'(1);
               bus.mem_read_valid   <= 1'b1;
               bus.mem_read_address <= {a_tag, a_idx, beat_q + OFF'(1)};
            end
            S_RESPOND: begin
               bus.read_data  <= data_mem[victim_q][a_idx][a_off];
               bus.read_ready <= 1'b1;
            end
            S_FLUSH: begin
               valid[0][flush_idx] <= 1'b0;
               valid[1][flush_idx] <= 1'b0;
               lru[flush_idx]      <= 1'b0;
               flush_idx           <= flush_idx + IDX'(1);
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (state == S_REFILL_REQ && bus.mem_read_ready) begin
         data_mem[victim_q][a_idx][beat_q] <= bus.mem_read_data;
         if (last_beat) tag_mem[victim_q][a_idx] <= a_tag;
      end
   end
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios plus random fetches checked against
// a set/way/LRU reference model and a flat program-memory image.
module tb_icache_assoc;
   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        busy;
   logic [15:0] hit_count, miss_count;

   icache_assoc_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

   icache_assoc dut (
      .clk(clk), .reset(reset), .bus(bus), .flush(flush),
      .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   int          n_cmp = 0;
   int          n_bad = 0;

   bit m_valid [4][2];
   int m_tag   [4][2];
   int m_lru   [4];
   int exp_hits, exp_misses;

   int          mem_wait = 0;
   int          mrv_cycles = 0;
   int          stable_err = 0;
   int          beat_cnt = 0;
   logic [7:0]  beat_addr;
   logic [7:0]  mem_log [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Memory controller: answers each request after mem_wait idle cycles.
   always @(negedge clk) begin
      if (reset || bus.mem_read_valid !== 1'b1) begin
         beat_cnt           = 0;
         bus.mem_read_ready = 1'b0;
         bus.mem_read_data  = 16'h0;
      end else begin
         if (beat_cnt == 0) begin
            beat_addr = bus.mem_read_address;
            mem_log.push_back(bus.mem_read_address);
         end else if (bus.mem_read_address !== beat_addr) begin
            stable_err++;
         end
         mrv_cycles++;
         bus.mem_read_ready = (beat_cnt == mem_wait);
         bus.mem_read_data  = mem[bus.mem_read_address];
         beat_cnt++;
      end
   end

   function automatic void model_clear(input bit clr_counts);
      for (int s = 0; s < 4; s++) begin
         m_valid[s][0] = 0;
         m_valid[s][1] = 0;
         m_lru[s]      = 0;
      end
      if (clr_counts) begin
         exp_hits   = 0;
         exp_misses = 0;
      end
   endfunction

   function automatic bit model_access(input logic [7:0] a);
      int s, t, v;
      s = (int'(a) / 4) % 4;
      t = int'(a) / 16;
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) begin
            m_lru[s] = 1 - w;
            return 1'b1;
         end
      if (!m_valid[s][0])      v = 0;
      else if (!m_valid[s][1]) v = 1;
      else                     v = m_lru[s];
      m_valid[s][v] = 1;
      m_tag[s][v]   = t;
      m_lru[s]      = 1 - v;
      return 1'b0;
   endfunction

   task automatic wait_idle();
      int k;
      @(negedge clk);
      for (k = 0; k < 60; k++) begin
         if (!busy && !bus.read_ready) break;
         @(negedge clk);
      end
      if (k == 60) check_val("idle_timeout", 32'(busy), 32'h0);
   endtask

   task automatic count_flush();
      int n = 0;
      for (int k = 0; k < 20; k++) begin
         if (!busy) break;
         n++;
         @(posedge clk); #1;
      end
      check_val("flush_cycles", n, 4);
   endtask

   task automatic do_flush();
      wait_idle();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      count_flush();
      model_clear(1'b0);
   endtask

   task automatic do_read(input logic [7:0] a, input int w, input int flush_cyc, output bit got_hit);
      bit exp_hit;
      int lat = 0;
      int exp_lat;
      exp_hit = model_access(a);
      if (exp_hit) exp_hits++; else exp_misses++;
      exp_lat = exp_hit ? 1 : 4 * (w + 2) + 1;
      wait_idle();
      mem_log.delete();
      mrv_cycles = 0;
      mem_wait   = w;
      bus.read_valid   = 1'b1;
      bus.read_address = a;
      @(posedge clk); #1;
      bus.read_valid = 1'b0;
      for (int n = 1; n <= 120; n++) begin
         @(posedge clk); #1;
         if (flush) flush = 1'b0;
         if (n == flush_cyc) flush = 1'b1;
         if (bus.read_ready) begin
            lat = n;
            break;
         end
      end
      got_hit = (lat == 1);
      check_val($sformatf("latency@%0h", a), lat, exp_lat);
      check_val($sformatf("data@%0h", a), bus.read_data, mem[a]);
      check_val("hit_count", hit_count, exp_hits);
      check_val("miss_count", miss_count, exp_misses);
      check_val("beats", mem_log.size(), exp_hit ? 0 : 4);
      for (int i = 0; i < mem_log.size() && i < 4; i++)
         check_val($sformatf("beat_addr%0d", i), mem_log[i], (int'(a) & 8'hFC) + i);
      check_val("mrv_cycles", mrv_cycles, exp_hit ? 0 : 4 * (w + 1));
   endtask

   bit h;
   bit lru_pat [6] = '{0, 0, 1, 0, 1, 0};
   logic [7:0] lru_addr [6] = '{8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h10};

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      bus.read_valid   = 1'b0;
      bus.read_address = 8'h0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      model_clear(1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_read_ready", bus.read_ready, 0);
      check_val("rst_read_data", bus.read_data, 0);
      check_val("rst_mem_valid", bus.mem_read_valid, 0);
      check_val("rst_mem_addr", bus.mem_read_address, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_hits", hit_count, 0);
      check_val("rst_misses", miss_count, 0);
      @(negedge clk);
      reset = 1'b0;

      do_read(8'h05, 0, 0, h);
      do_read(8'h06, 0, 0, h);
      for (int i = 0; i < 6; i++) begin
         do_read(lru_addr[i], 0, 0, h);
         check_val($sformatf("lru_seq%0d", i), h, lru_pat[i]);
      end
      do_read(8'h33, 3, 0, h);

      // Flush raised in the middle of a refill is deferred until the read returns.
      do_read(8'h45, 0, 5, h);
      @(posedge clk); #1;
      count_flush();
      model_clear(1'b0);
      do_read(8'h45, 0, 0, h);
      check_val("miss_after_flush", h, 0);

      // Reset while a beat is outstanding.
      wait_idle();
      mem_wait = 3;
      bus.read_valid   = 1'b1;
      bus.read_address = 8'hC9;
      @(posedge clk); #1;
      bus.read_valid = 1'b0;
      @(posedge clk); #1;
      check_val("refill_mrv", bus.mem_read_valid, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_val("abort_mrv", bus.mem_read_valid, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_hits", hit_count, 0);
      check_val("abort_misses", miss_count, 0);
      @(negedge clk);
      reset = 1'b0;
      model_clear(1'b1);
      do_read(8'hC9, 0, 0, h);
      check_val("miss_after_reset", h, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) do_flush();
         do_read(8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), 0, h);
      end
      check_val("addr_stable", stable_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
